// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state encoding, port identifiers and default widths for mem_arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int STARVE_MAX_DEF = 4;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_IO = 1'b1;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;
endpackage

// File: rtl/mem_arbiter_pick2.sv
// arb_pick2: two-way winner selection; on contention port 1 wins when rr_ptr or starve_hit is set.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_ptr,
  input  logic       starve_hit,
  output logic       valid,
  output logic       id
);
  // The top ties off whichever of rr_ptr/starve_hit its policy does not use.
  always_comb begin
    valid = |req;
    id = &req ? (rr_ptr | starve_hit) : (req[1] ? PORT_IO : PORT_CPU);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises CPU (port 0) and I/O (port 1) accesses onto a single-port synchronous memory.
// Round robin by default; define ARB_FIXED_PRIO_EN for CPU priority with an I/O starvation override.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_ack,
  output logic [DATA_W-1:0] io_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_starve_range
    $error("STARVE_MAX must be in 1..15");
  end

  state_t state_q, state_d;
  logic we_q, we_d, grant_id_q, grant_id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, cpu_rdata_q, cpu_rdata_d, io_rdata_q, io_rdata_d;
  logic rr_ptr, starve_hit, pick_valid, pick_id;

  arb_pick2 u_pick (
    .req       ({io_req, cpu_req}),
    .rr_ptr    (rr_ptr),
    .starve_hit(starve_hit),
    .valid     (pick_valid),
    .id        (pick_id)
  );

  always_comb begin
    state_d = state_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    grant_id_d = grant_id_q;
    cpu_rdata_d = cpu_rdata_q;
    io_rdata_d = io_rdata_q;
    unique case (state_q)
      IDLE: if (pick_valid) begin
        state_d = ACCESS;
        grant_id_d = pick_id;
        we_d = pick_id == PORT_IO ? io_we : cpu_we;
        addr_d = pick_id == PORT_IO ? io_addr : cpu_addr;
        wdata_d = pick_id == PORT_IO ? io_wdata : cpu_wdata;
      end
      ACCESS: state_d = RESP;
      RESP: begin
        state_d = IDLE;
        cpu_rdata_d = !we_q && grant_id_q == PORT_CPU ? mem_rdata : cpu_rdata_q;
        io_rdata_d = !we_q && grant_id_q == PORT_IO ? mem_rdata : io_rdata_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      grant_id_q <= PORT_CPU;
      cpu_rdata_q <= '0;
      io_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      grant_id_q <= grant_id_d;
      cpu_rdata_q <= cpu_rdata_d;
      io_rdata_q <= io_rdata_d;
    end
  end

`ifdef ARB_FIXED_PRIO_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_q, starve_d;
  assign rr_ptr = PORT_CPU;
  assign starve_hit = starve_q >= STARVE_LIM;
  // Counts IDLE cycles where port 1 asked and lost; saturates so it can never wrap past the limit.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE && io_req)
      starve_d = pick_id == PORT_IO ? 4'd0 : (&starve_q ? starve_q : starve_q + 4'd1);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) starve_q <= 4'd0;
    else starve_q <= starve_d;
  end
`else
  logic rr_ptr_q, rr_ptr_d;
  assign rr_ptr = rr_ptr_q;
  assign starve_hit = 1'b0;
  always_comb rr_ptr_d = state_q == RESP ? ~grant_id_q : rr_ptr_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rr_ptr_q <= PORT_CPU;
    else rr_ptr_q <= rr_ptr_d;
  end
`endif

  // Read data passes straight through in the ack cycle and is held afterwards.
  assign cpu_rdata = cpu_rdata_d;
  assign io_rdata = io_rdata_d;
  assign busy = state_q == ACCESS || state_q == RESP;
  assign mem_en = state_q == ACCESS;
  assign mem_we = mem_en & we_q;
  assign mem_addr = mem_en ? addr_q : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;
  assign cpu_ack = state_q == RESP && grant_id_q == PORT_CPU;
  assign io_ack = state_q == RESP && grant_id_q == PORT_IO;
  assign grant_id = grant_id_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  localparam int SM = 4;
  logic clock = 1'b0, reset = 1'b0;
  logic cpu_req = 1'b0, cpu_we = 1'b0, io_req = 1'b0, io_we = 1'b0;
  logic [7:0] cpu_addr = '0, cpu_wdata = '0, io_addr = '0, io_wdata = '0;
  logic cpu_ack, io_ack, mem_en, mem_we, busy, grant_id;
  logic [7:0] cpu_rdata, io_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [37:0] outs;
  int checks = 0, failures = 0;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_MAX(SM)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ack(io_ack), .io_rdata(io_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  always #5 clock = ~clock;
  assign outs = {cpu_ack, io_ack, mem_en, mem_we, mem_addr, mem_wdata, busy, grant_id, cpu_rdata, io_rdata};

  // Synchronous single-port memory, reloaded with a known pattern while reset is low.
  logic [7:0] mem [256];
  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 5);
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end

  logic [7:0] ref_mem [256];
  logic [7:0] exp_rd [2];
  logic m_pref;
  int m_starve;
  logic pend [2], op_we [2];
  logic [7:0] op_addr [2], op_wd [2];

  function automatic void model_reset();
    m_pref = 1'b0;
    m_starve = 0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 5);
  endfunction

  function automatic logic model_pick(input logic [1:0] r);
    if (r != 2'b11) return r[1];
`ifdef ARB_FIXED_PRIO_EN
    return m_starve >= SM;
`else
    return m_pref;
`endif
  endfunction

  function automatic void model_grant(input logic id, input logic io_wanted);
    m_pref = ~id;
    if (id) m_starve = 0;
    else if (io_wanted && m_starve < 15) m_starve++;
  endfunction

  task automatic drive();
    cpu_req = pend[0]; cpu_we = op_we[0]; cpu_addr = op_addr[0]; cpu_wdata = op_wd[0];
    io_req = pend[1]; io_we = op_we[1]; io_addr = op_addr[1]; io_wdata = op_wd[1];
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  // One isolated transaction from an idle arbiter; reports cycle numbers counted from the request.
  task automatic xact(input logic p, input logic we, input logic [7:0] a, input logic [7:0] wd,
                      output int en_cyc, output int ack_cyc, output logic [7:0] rd);
    en_cyc = -1; ack_cyc = -1; rd = '0;
    pend[p] = 1'b1; op_we[p] = we; op_addr[p] = a; op_wd[p] = wd;
    drive();
    for (int c = 1; c <= 12 && ack_cyc < 0; c++) begin
      @(negedge clock);
      if (mem_en && en_cyc < 0) en_cyc = c;
      if (p ? io_ack : cpu_ack) begin
        ack_cyc = c;
        rd = p ? io_rdata : cpu_rdata;
      end
    end
    @(posedge clock); #1;
    pend[p] = 1'b0;
    drive();
    model_grant(p, 1'b0);
    if (we) ref_mem[a] = wd;
    else exp_rd[p] = ref_mem[a];
  endtask

  task automatic test_reset();
    int en_c, ack_c, acks;
    logic [7:0] rd;
    checks++; if (outs !== '0) begin failures++; $display("FAIL reset_outs got=%h exp=0", outs); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (outs !== '0) begin failures++; $display("FAIL idle_outs got=%h exp=0", outs); end
    @(posedge clock); #1;
    pend[0] = 1'b1; op_we[0] = 1'b0; op_addr[0] = 8'h10; op_wd[0] = '0;
    drive();
    @(negedge clock);
    @(negedge clock);
    checks++; if (mem_en !== 1'b1) begin failures++; $display("FAIL access_before_reset got=%b exp=1", mem_en); end
    reset = 1'b0;
    #1;
    checks++; if (outs !== '0) begin failures++; $display("FAIL midreset_outs got=%h exp=0", outs); end
    pend[0] = 1'b0;
    drive();
    acks = 0;
    repeat (3) begin
      @(negedge clock);
      if (cpu_ack || io_ack) acks++;
    end
    checks++; if (acks != 0) begin failures++; $display("FAIL abandoned_ack got=%0d exp=0", acks); end
    @(posedge clock); #1;
    reset = 1'b1;
    model_reset();
    xact(1'b0, 1'b0, 8'h10, 8'h00, en_c, ack_c, rd);
    checks++; if (ack_c != 3) begin failures++; $display("FAIL post_reset_ack_cycle got=%0d exp=3", ack_c); end
    checks++; if (rd !== ref_mem[8'h10]) begin failures++; $display("FAIL post_reset_rdata got=%h exp=%h", rd, ref_mem[8'h10]); end
  endtask

  task automatic test_write_read();
    int en_c, ack_c;
    logic [7:0] rd;
    xact(1'b0, 1'b1, 8'h20, 8'h5A, en_c, ack_c, rd);
    checks++; if (en_c != 2 || ack_c != 3) begin failures++; $display("FAIL wr_timing got=%0d/%0d exp=2/3", en_c, ack_c); end
    checks++; if (cpu_rdata !== exp_rd[0]) begin failures++; $display("FAIL wr_rdata_kept got=%h exp=%h", cpu_rdata, exp_rd[0]); end
    xact(1'b0, 1'b0, 8'h20, 8'h00, en_c, ack_c, rd);
    checks++; if (en_c != 2 || ack_c != 3) begin failures++; $display("FAIL rd_timing got=%0d/%0d exp=2/3", en_c, ack_c); end
    checks++; if (rd !== 8'h5A) begin failures++; $display("FAIL rd_data got=%h exp=5a", rd); end
    @(negedge clock);
    checks++; if (cpu_rdata !== 8'h5A || busy !== 1'b0) begin failures++; $display("FAIL rd_hold got=%h/%b exp=5a/0", cpu_rdata, busy); end
    @(posedge clock); #1;
  endtask

  task automatic test_io_then_cpu();
    int en_c, ack_c;
    logic [7:0] rd, io_before;
    io_before = exp_rd[1];
    xact(1'b1, 1'b1, 8'h30, 8'hC3, en_c, ack_c, rd);
    checks++; if (en_c != 2 || ack_c != 3) begin failures++; $display("FAIL io_wr_timing got=%0d/%0d exp=2/3", en_c, ack_c); end
    checks++; if (grant_id !== 1'b1) begin failures++; $display("FAIL io_grant_id got=%b exp=1", grant_id); end
    xact(1'b0, 1'b0, 8'h30, 8'h00, en_c, ack_c, rd);
    checks++; if (ack_c != 3 || rd !== 8'hC3) begin failures++; $display("FAIL cpu_raw got=%0d/%h exp=3/c3", ack_c, rd); end
    checks++; if (io_rdata !== io_before || grant_id !== 1'b0) begin failures++; $display("FAIL io_rdata_kept got=%h/%b exp=%h/0", io_rdata, grant_id, io_before); end
  endtask

  task automatic test_drop();
    int acks, io_acks, ens;
    logic [7:0] a;
    acks = 0; io_acks = 0; ens = 0;
    a = 8'($urandom_range(0, 255));
    pend[0] = 1'b1; op_we[0] = 1'b0; op_addr[0] = a;
    drive();
    @(negedge clock);
    if (mem_en) ens++;
    @(posedge clock); #1;
    pend[0] = 1'b0;
    drive();
    repeat (8) begin
      @(negedge clock);
      if (mem_en) ens++;
      if (cpu_ack) acks++;
      if (io_ack) io_acks++;
    end
    checks++; if (acks != 1 || io_acks != 0) begin failures++; $display("FAIL drop_acks got=%0d/%0d exp=1/0", acks, io_acks); end
    checks++; if (ens != 1 || busy !== 1'b0) begin failures++; $display("FAIL drop_access got=%0d/%b exp=1/0", ens, busy); end
    checks++; if (cpu_rdata !== ref_mem[a]) begin failures++; $display("FAIL drop_rdata got=%h exp=%h", cpu_rdata, ref_mem[a]); end
    model_grant(1'b0, 1'b0);
    exp_rd[0] = ref_mem[a];
    @(posedge clock); #1;
  endtask

  task automatic test_fairness();
    logic sq [$];
    logic ex [$];
    int cyc, last;
    logic p;
`ifdef ARB_FIXED_PRIO_EN
    ex = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    ex = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
    do_reset();
    cyc = 0; last = 0;
    for (int k = 0; k < 2; k++) begin
      pend[k] = 1'b1; op_we[k] = 1'b0; op_addr[k] = 8'(k + 64);
    end
    drive();
    while (sq.size() < ex.size() && cyc < 100) begin
      @(negedge clock);
      cyc++;
      checks++; if (cpu_ack && io_ack) begin failures++; $display("FAIL fair_dual_ack cycle=%0d exp=single", cyc); end
      if (cpu_ack || io_ack) begin
        p = io_ack;
        checks++; if (cyc - last != 3) begin failures++; $display("FAIL fair_spacing got=%0d exp=3", cyc - last); end
        last = cyc;
        sq.push_back(p);
        model_grant(p, 1'b1);
        exp_rd[p] = ref_mem[op_addr[p]];
      end
      @(posedge clock); #1;
    end
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive();
    checks++; if (sq.size() != ex.size()) begin failures++; $display("FAIL fair_count got=%0d exp=%0d", sq.size(), ex.size()); end
    foreach (ex[i]) begin
      checks++;
      if ((i < sq.size() ? sq[i] : 1'bx) !== ex[i]) begin
        failures++; $display("FAIL fair_grant idx=%0d got=%b exp=%b", i, i < sq.size() ? sq[i] : 1'bx, ex[i]);
      end
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_random(input int n_tx);
    int issued, done, cyc, acc_cyc;
    logic [1:0] rq1, rq2;
    logic acc_we, p;
    logic [7:0] acc_a, acc_d;
    issued = 0; done = 0; cyc = 0; acc_cyc = -9;
    rq1 = '0; rq2 = '0; acc_we = 1'b0; acc_a = '0; acc_d = '0;
    while (done < n_tx && cyc < n_tx * 10 + 50) begin
      for (int k = 0; k < 2; k++)
        if (!pend[k] && issued < n_tx && $urandom_range(0, 99) < 60) begin
          pend[k] = 1'b1;
          op_we[k] = 1'($urandom_range(0, 1));
          op_addr[k] = 8'($urandom_range(0, 15));
          op_wd[k] = 8'($urandom);
          issued++;
        end
      drive();
      @(negedge clock);
      cyc++;
      checks++; if ((cpu_ack && io_ack) || (mem_en && !busy)) begin failures++; $display("FAIL rnd_exclusive cycle=%0d acks=%b%b en=%b busy=%b", cyc, cpu_ack, io_ack, mem_en, busy); end
      if (mem_en) begin
        acc_cyc = cyc; acc_we = mem_we; acc_a = mem_addr; acc_d = mem_wdata;
      end
      if (cpu_ack || io_ack) begin
        p = io_ack;
        checks++; if (!rq2[p] || p !== model_pick(rq2)) begin failures++; $display("FAIL rnd_winner cycle=%0d got=%b exp=%b req=%b", cyc, p, model_pick(rq2), rq2); end
        checks++;
        if (acc_cyc != cyc - 1 || {acc_we, acc_a} !== {op_we[p], op_addr[p]} || (op_we[p] && acc_d !== op_wd[p])) begin
          failures++; $display("FAIL rnd_access cycle=%0d got=%b/%h/%h exp=%b/%h/%h", cyc, acc_we, acc_a, acc_d, op_we[p], op_addr[p], op_wd[p]);
        end
        if (op_we[p]) ref_mem[op_addr[p]] = op_wd[p];
        else exp_rd[p] = ref_mem[op_addr[p]];
        checks++; if (cpu_rdata !== exp_rd[0] || io_rdata !== exp_rd[1]) begin failures++; $display("FAIL rnd_rdata cycle=%0d got=%h/%h exp=%h/%h", cyc, cpu_rdata, io_rdata, exp_rd[0], exp_rd[1]); end
        model_grant(p, rq2[1]);
        pend[p] = 1'b0;
        done++;
      end
      rq2 = rq1;
      rq1 = {io_req, cpu_req};
      @(posedge clock); #1;
    end
    checks++; if (done != n_tx) begin failures++; $display("FAIL rnd_timeout got=%0d exp=%0d", done, n_tx); end
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      pend[k] = 1'b0; op_we[k] = 1'b0; op_addr[k] = '0; op_wd[k] = '0;
    end
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_write_read();
    test_io_then_cpu();
    test_drop();
    test_fairness();
    test_random(200);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
